// File: rtl/button_conditioner.sv
// Four-button front end for the block mover: synchronise, debounce, auto-repeat,
// then arbitrate to at most one direction pulse per cycle (right > left > up > down).
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic       right,
  output logic       left,
  output logic       up,
  output logic       down,
  output logic [3:0] btn_level
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_ZERO  = RPT_W'(0);
  localparam logic [RPT_W-1:0] RPT_ONE   = RPT_W'(1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } state_e;

  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] pulse_s;
  logic [3:0] level_s;

  // two-flop synchroniser for the asynchronous button pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_btn
    state_e           state_q, state_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             pulse_q, pulse_d;

    // per-button debounce/repeat state registers
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q   <= IDLE;
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        pulse_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        db_cnt_q  <= db_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        pulse_q   <= pulse_d;
      end
    end

    // next-state logic; a release glitch back to HELD keeps the repeat phase intact
    always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      rpt_cnt_d = rpt_cnt_q;
      pulse_d   = 1'b0;
      case (state_q)
        IDLE: begin
          if (sync2_q[g]) begin
            state_d  = DB_PRESS;
            db_cnt_d = DB_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        DB_PRESS: begin
          if (!sync2_q[g]) begin
            state_d = IDLE;
          end else if (db_cnt_q == DB_LAST) begin
            state_d   = HELD;
            pulse_d   = 1'b1;
            rpt_cnt_d = RPT_FIRST;
          end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end
        end
        HELD: begin
          if (!sync2_q[g]) begin
            state_d  = DB_RELEASE;
            db_cnt_d = DB_ONE;
          end else if (REPEAT_EN && (rpt_cnt_q == RPT_ZERO)) begin
            pulse_d   = 1'b1;
            rpt_cnt_d = RPT_NEXT;
          end else if (rpt_cnt_q != RPT_ZERO) begin
            rpt_cnt_d = rpt_cnt_q - RPT_ONE;
          end else begin
            rpt_cnt_d = RPT_ZERO;
          end
        end
        DB_RELEASE: begin
          if (sync2_q[g]) begin
            state_d = HELD;
          end else if (db_cnt_q == DB_LAST) begin
            state_d = IDLE;
          end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    assign pulse_s[g] = pulse_q;
    assign level_s[g] = (state_q == HELD) || (state_q == DB_RELEASE);
  end

  assign right     = pulse_s[3];
  assign left      = pulse_s[2] & ~pulse_s[3];
  assign up        = pulse_s[1] & ~|pulse_s[3:2];
  assign down      = pulse_s[0] & ~|pulse_s[3:1];
  assign btn_level = level_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/repeat settings;
// edge e is the e-th rising edge after stimulus starts, outputs checked 1 time unit later.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic       right, left, up, down;
  logic [3:0] btn_level;
  logic [3:0] pulses;
  logic [3:0] exp_p;
  logic [3:0] exp_l;
  int         total;
  int         bad;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .REPEAT_EN      (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .right    (right),
    .left     (left),
    .up       (up),
    .down     (down),
    .btn_level(btn_level)
  );

  assign pulses = {right, left, up, down};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    btn_raw = 4'h0;
    rst     = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    btn_raw = 4'hF;

    // 1: reset with all buttons down, then release reset while held
    #2;
    check_eq("t1_rst_pulse", pulses, 4'h0);
    check_eq("t1_rst_level", btn_level, 4'h0);
    tick();
    tick();
    tick();
    check_eq("t1_rst_pulse_late", pulses, 4'h0);
    check_eq("t1_rst_level_late", btn_level, 4'h0);
    rst = 1'b1;
    for (int e = 0; e < 12; e++) begin
      btn_raw = 4'hF;
      tick();
      exp_p = (e == 5) ? 4'b1000 : 4'b0000;
      exp_l = (e >= 5) ? 4'hF : 4'h0;
      check_eq($sformatf("t1_pulse_e%0d", e), pulses, exp_p);
      check_eq($sformatf("t1_level_e%0d", e), btn_level, exp_l);
    end
    do_reset();

    // 2: clean press of up, held 10 edges
    for (int e = 0; e < 18; e++) begin
      btn_raw = (e <= 9) ? 4'b0010 : 4'b0000;
      tick();
      exp_p = (e == 5) ? 4'b0010 : 4'b0000;
      exp_l = (e >= 5 && e <= 14) ? 4'b0010 : 4'b0000;
      check_eq($sformatf("t2_pulse_e%0d", e), pulses, exp_p);
      check_eq($sformatf("t2_level_e%0d", e), btn_level, exp_l);
    end
    do_reset();

    // 3: down bounces (high 3, low 1) then settles high from edge 4
    for (int e = 0; e < 16; e++) begin
      btn_raw = (e == 3) ? 4'b0000 : 4'b0001;
      tick();
      exp_p = (e == 9) ? 4'b0001 : 4'b0000;
      exp_l = (e >= 9) ? 4'b0001 : 4'b0000;
      check_eq($sformatf("t3_pulse_e%0d", e), pulses, exp_p);
      check_eq($sformatf("t3_level_e%0d", e), btn_level, exp_l);
    end
    do_reset();

    // 4: right held 60 edges, auto-repeat then release
    for (int e = 0; e < 72; e++) begin
      btn_raw = (e <= 59) ? 4'b1000 : 4'b0000;
      tick();
      exp_p = (e == 5 || e == 25 || e == 33 || e == 41 || e == 49 || e == 57)
              ? 4'b1000 : 4'b0000;
      exp_l = (e >= 5 && e <= 64) ? 4'b1000 : 4'b0000;
      check_eq($sformatf("t4_pulse_e%0d", e), pulses, exp_p);
      check_eq($sformatf("t4_level_e%0d", e), btn_level, exp_l);
    end
    do_reset();

    // 5: right and left pressed together
    for (int e = 0; e < 20; e++) begin
      btn_raw = (e <= 11) ? 4'b1100 : 4'b0000;
      tick();
      exp_p = (e == 5) ? 4'b1000 : 4'b0000;
      exp_l = (e >= 5 && e <= 16) ? 4'b1100 : 4'b0000;
      check_eq($sformatf("t5_pulse_e%0d", e), pulses, exp_p);
      check_eq($sformatf("t5_level_e%0d", e), btn_level, exp_l);
    end
    do_reset();

    // 6: reset asserted mid-hold at edge 15
    for (int e = 0; e < 16; e++) begin
      btn_raw = 4'b1000;
      tick();
      exp_p = (e == 5) ? 4'b1000 : 4'b0000;
      exp_l = (e >= 5) ? 4'b1000 : 4'b0000;
      check_eq($sformatf("t6_pulse_e%0d", e), pulses, exp_p);
      check_eq($sformatf("t6_level_e%0d", e), btn_level, exp_l);
    end
    rst = 1'b0;
    #1;
    check_eq("t6_async_pulse", pulses, 4'h0);
    check_eq("t6_async_level", btn_level, 4'h0);
    btn_raw = 4'h0;
    tick();
    check_eq("t6_inrst_level", btn_level, 4'h0);
    tick();
    rst = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      check_eq($sformatf("t6_post_pulse_e%0d", e), pulses, 4'h0);
      check_eq($sformatf("t6_post_level_e%0d", e), btn_level, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
